// File: rtl/serial_adder_seq.sv
// rtl/serial_adder_seq.sv - bit-serial LSB-first adder around a 1-bit full-adder cell
// Optional two's-complement overflow output enabled by SERIAL_ADDER_OVF_EN.
module serial_adder_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fa_s, fa_c, last_bit;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    assign fa_s     = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    assign fa_c     = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_RUN: begin
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                carry_d = fa_c;
                cnt_d   = cnt_q + CW'(1);
                if (last_bit) begin
                    state_d = S_DONE;
                    cout_d  = fa_c;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry_q is the carry into the MSB on this final cycle
                    ovf_d   = carry_q ^ fa_c;
`endif
                end
            end
            default: begin
                // IDLE and DONE both accept a new operation
                if (start) begin
                    state_d = S_RUN;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_seq.sv
// tb/tb_serial_adder_seq.sv - scoreboard bench for serial_adder_seq at WIDTH=4
module tb_serial_adder_seq;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n, start, cin;
    logic [W-1:0] a, b;
    logic         busy, done, cout;
    logic [W-1:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int vectors = 0;
    int miscompares = 0;
    logic [5:0] sb[$];
    logic [5:0] e_mon;

    serial_adder_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {ovf, cout, sum}; ovf from carry into bit W-1 versus carry out
    function automatic logic [5:0] mk_exp(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                         input logic tc);
        logic [4:0] full;
        int         lo;
        logic       c3;
        full = {1'b0, ta} + {1'b0, tb_} + 5'(tc);
        lo   = int'(ta[2:0]) + int'(tb_[2:0]) + int'(tc);
        c3   = (lo >= 8);
        return {c3 ^ full[4], full};
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e_mon = sb.pop_front();
                chk("sum", 32'(sum), 32'(e_mon[3:0]));
                chk("cout", 32'(cout), 32'(e_mon[4]));
`ifdef SERIAL_ADDER_OVF_EN
                chk("ovf", 32'(ovf), 32'(e_mon[5]));
`endif
            end
        end
    end

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                          input bit zero_mid);
        logic [5:0] exp;
        exp = mk_exp(ta, tb_, tc);
        a = ta; b = tb_; cin = tc; start = 1'b1;
        sb.push_back(exp);
        tick();
        start = 1'b0;
        if (zero_mid) begin
            a = '0; b = '0; cin = 1'b0;
        end else begin
            a = ~ta; b = ~tb_; cin = ~tc;
        end
        for (int i = 0; i < W; i++) begin
            chk("busy_run", 32'(busy), 32'd1);
            chk("done_run", 32'(done), 32'd0);
            tick();
        end
        chk("busy_done", 32'(busy), 32'd0);
        chk("done_pulse", 32'(done), 32'd1);
        tick();
        tick();
        chk("idle_done", 32'(done), 32'd0);
        chk("hold_sum", 32'(sum), 32'(exp[3:0]));
        chk("hold_cout", 32'(cout), 32'(exp[4]));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        tick();

        run_op(4'd5, 4'd3, 1'b0, 1'b0);
        run_op(4'd15, 4'd1, 1'b0, 1'b0);
        run_op(4'd15, 4'd15, 1'b1, 1'b0);
        run_op(4'd0, 4'd0, 1'b0, 1'b0);

        // Back-to-back: start held high, second pair loads in the DONE cycle
        a = 4'd2; b = 4'd2; cin = 1'b0; start = 1'b1;
        sb.push_back(mk_exp(4'd2, 4'd2, 1'b0));
        sb.push_back(mk_exp(4'd7, 4'd9, 1'b0));
        tick();
        for (int i = 1; i <= 10; i++) begin
            if (i == 1) begin a = 4'd7; b = 4'd9; end
            if (i == 6) start = 1'b0;
            chk("b2b_done", 32'(done), 32'((i == 5) || (i == 10)));
            chk("b2b_busy", 32'(busy), 32'(!((i == 5) || (i == 10))));
            tick();
        end
        chk("b2b_idle", 32'(busy | done), 32'd0);
        tick();

        // Reset in the second RUN cycle aborts with no done pulse
        a = 4'd3; b = 4'd4; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("abort_ovf", 32'(ovf), 32'd0);
`endif
        for (int i = 0; i < 8; i++) begin
            chk("abort_no_done", 32'(done), 32'd0);
            tick();
        end
        run_op(4'd1, 4'd1, 1'b0, 1'b0);

        run_op(4'd6, 4'd1, 1'b0, 1'b1);

`ifdef SERIAL_ADDER_OVF_EN
        run_op(4'd7, 4'd1, 1'b0, 1'b0);
        run_op(4'd12, 4'd4, 1'b0, 1'b0);
`endif

        for (int k = 0; k < 4; k++) begin
            run_op(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)), 1'b0);
        end

        tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_adder_seq.md
Name: serial_adder_seq

Overview:
- Bit-serial adder: takes two WIDTH-bit operands plus carry-in, adds them LSB-first, one bit per clock, through a single 1-bit full-adder cell with a registered carry.
- Sits directly around the team's combinational full-adder cell (S = A^B^C, Cout = A&B | C&(A^B)). It supplies the cell's per-cycle operand bits and captures its sum/carry outputs.
- Trades area for latency in the arithmetic datapath.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, synchronous active-low reset.
- start, input, 1, request to begin an addition; sampled on clk.
- a, input, WIDTH, operand A; captured only when start is accepted.
- b, input, WIDTH, operand B; captured only when start is accepted.
- cin, input, 1, carry-in; captured only when start is accepted.
- busy, output, 1, high while bits are being processed.
- done, output, 1, one-cycle pulse: sum/cout are valid.
- sum, output, WIDTH, result bits WIDTH-1..0.
- cout, output, 1, final carry-out.

Behaviour:
- Reset: on a rising edge with rst_n=0, clear everything regardless of state.
  - State goes to IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - Operand shift registers, carry register and bit counter are cleared.
  - Reset mid-RUN aborts the operation; done is never pulsed for it.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 loads a, b into shift registers and cin into the carry register, clears the bit counter, goes to RUN. start=0 stays in IDLE.
  - RUN: busy=1. Each cycle, the full-adder computes s = a_sh[0]^b_sh[0]^carry and c = a_sh[0]&b_sh[0] | carry&(a_sh[0]^b_sh[0]).
    - a_sh and b_sh shift right by 1.
    - s enters the sum register at bit WIDTH-1 while the sum register shifts right.
    - carry <= c; counter increments.
    - When the counter reaches WIDTH-1 (the last bit processed), go to DONE.
    - start is ignored in RUN.
  - DONE: lasts exactly one cycle.
    - done=1, busy=0, cout = carry register, sum holds the final value.
    - If start=1, new operands load and the FSM goes to RUN (back-to-back). Otherwise go to IDLE.
- Latency: start accepted at edge N. busy is high for cycles N+1..N+WIDTH. done is high in cycle N+WIDTH+1.
- Result holding:
  - sum and cout keep their values after done until the next accepted start.
  - While a new operation is running, sum shows partial shifting contents. Consumers must use only values qualified by done.
- Arithmetic: unsigned. {cout, sum} = a + b + cin, exact modulo 2^(WIDTH+1). No saturation.
- Counter width: clog2(WIDTH); the terminal compare is at WIDTH-1.
- Boundaries:
  - All-ones + all-ones with cin=1 gives sum = all-ones, cout=1.
  - Zero operands with cin=0 gives sum=0, cout=0.
  - Changes on a, b, cin outside the accept cycle have no effect.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit). It is the two's-complement overflow flag: the carry into the MSB XOR the carry out of the MSB.
  - ovf is captured on the final RUN cycle and is valid with done; it holds like sum.
  - Reset value is 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. WIDTH=4: a=5, b=3, cin=0, start for 1 cycle → busy high 4 cycles, done in cycle 5 after accept, sum=8, cout=0.
2. WIDTH=4: a=15, b=1, cin=0 → sum=0, cout=1. Then a=15, b=15, cin=1 → sum=15, cout=1.
3. start held high continuously with alternating operand pairs (2+2, then 7+9) → the second operation loads in the DONE cycle. done pulses every 5 cycles with results 4/0 then 0/1. start is ignored during RUN.
4. Assert rst_n=0 in the 2nd RUN cycle for 1 cycle → next cycle busy=0, done=0, sum=0, cout=0, state IDLE. No done pulse follows. A fresh 1+1 then gives sum=2.
5. Change a/b mid-RUN (load 6+1, then drive a=0, b=0) → result still sum=7, cout=0.
6. With SERIAL_ADDER_OVF_EN, WIDTH=4: 7+1 → sum=8, ovf=1, cout=0. Then 12+4 (−4+4) → sum=0, cout=1, ovf=0.
